// File: rtl/circuit1_sched_if.sv
// Bus bundle for circuit1_sched: operand request and result return.
// Handshake: a request is accepted on a rising edge where start=1 and busy=0;
// busy stays high until done pulses for one cycle with z and x valid.
interface circuit1_sched_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic        busy;
    logic        done;
    logic [7:0]  z;
    logic [15:0] x;

    modport master (
        output start, a, b, c,
        input  busy, done, z, x
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, z, x
    );
endinterface

// File: rtl/circuit1_sched.sv
// Multicycle scheduler computing z = min(a+b, a+c) and x = a*c - (a+b) over one
// shared 16-bit adder/subtractor, one 16-bit multiplier and one comparator.
module circuit1_sched (
    input  logic             clk,
    input  logic             rst,
    circuit1_sched_if.slave  bus,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  c_q, c_d;
    logic [7:0]  d_q, d_d;
    logic [7:0]  e_q, e_d;
    logic [15:0] f_q, f_d;
    logic [7:0]  z_q, z_d;
    logic [15:0] x_q, x_d;

    // Shared datapath resources
    logic [15:0] add_op_a;
    logic [15:0] add_op_b;
    logic        add_sub;
    logic [15:0] add_y;
    logic [15:0] mul_op_a;
    logic [15:0] mul_op_c;
    logic [15:0] mul_y;
    logic        cmp_gt;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.busy  = (state_q != IDLE);
        bus.done  = (state_q == DONE);
        bus.z     = z_q;
        bus.x     = x_q;
        dbg_state = state_q;
    end

    // Adder operand steering: one operation per state, S3 subtracts.
    always_comb begin
        add_op_a = 16'd0;
        add_op_b = 16'd0;
        add_sub  = 1'b0;
        case (state_q)
            S1: begin
                add_op_a = {{8{a_q[7]}}, a_q};
                add_op_b = {{8{b_q[7]}}, b_q};
            end
            S2: begin
                add_op_a = {{8{a_q[7]}}, a_q};
                add_op_b = {{8{c_q[7]}}, c_q};
            end
            S3: begin
                add_op_a = f_q;
                add_op_b = {{8{d_q[7]}}, d_q};
                add_sub  = 1'b1;
            end
            default: begin
                add_op_a = 16'd0;
                add_op_b = 16'd0;
                add_sub  = 1'b0;
            end
        endcase
    end

    // The low 16 bits of a product do not depend on signedness, so a 16-bit
    // context on sign-extended operands yields the wrapped signed product.
    always_comb begin
        add_y    = add_sub ? (add_op_a - add_op_b) : (add_op_a + add_op_b);
        mul_op_a = {{8{a_q[7]}}, a_q};
        mul_op_c = {{8{c_q[7]}}, c_q};
        mul_y    = mul_op_a * mul_op_c;
        cmp_gt   = ($signed(d_q) > $signed(e_q));
    end

    // Datapath register next values
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        e_d = e_q;
        f_d = f_q;
        z_d = z_q;
        x_d = x_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    c_d = bus.c;
                end
            end
            S1: begin
                d_d = add_y[7:0];
                f_d = mul_y;
            end
            S2: begin
                e_d = add_y[7:0];
            end
            S3: begin
                x_d = add_y;
                // Tie keeps d: only a strict d>e selects e.
                z_d = cmp_gt ? e_q : d_q;
            end
            default: begin
                a_d = a_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 8'd0;
            b_q <= 8'd0;
            c_q <= 8'd0;
            d_q <= 8'd0;
            e_q <= 8'd0;
            f_q <= 16'd0;
            z_q <= 8'd0;
            x_q <= 16'd0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            e_q <= e_d;
            f_q <= f_d;
            z_q <= z_d;
            x_q <= x_d;
        end
    end

endmodule
